multdiv_sequencer: RTL and testbench
====================================

// Module: multdiv_sequencer
// PURPOSE
//  Sequences the iterative multiply/divide datapath in the X stage.
//  - Detects R-type mul/div instructions (opcode 00000, ALUop 00110 = mul, 00111 = div).
//  - Stalls the pipeline while the datapath runs, loads it, then steps it ITER times.
//  - Issues a one-cycle writeback: the result to rd, or on an exception the code to $rstatus.
// PARAMETERS
//  ITER        32  datapath iterations per operation (one bit per step)
//  CNT_W       6   iteration counter width; must satisfy 2**CNT_W > ITER
//  STATUS_REG  30  register index of $rstatus
//  MUL_EXC     4   $rstatus code for mul overflow
//  DIV_EXC     5   $rstatus code for div by zero
// PORTS
//  clock           in   1   system clock, rising edge
//  reset           in   1   synchronous, active-high
//  valid_in        in   1   X-stage instruction valid
//  opcode          in   5   X-stage opcode (instruction[31:27])
//  aluop           in   5   X-stage ALUop as produced by decode
//  rd_in           in   5   X-stage destination register
//  operand_b       in   32  X-stage B operand (divisor), used for the zero check
//  flush           in   1   squash the X stage (taken branch/jump)
//  dp_overflow     in   1   datapath mul-overflow flag, valid in DONE
//  stall           out  1   freeze F/D/X, insert bubble into M
//  dp_load         out  1   one-cycle pulse: datapath latches operands
//  dp_step         out  1   datapath performs one iteration
//  dp_is_div       out  1   latched op type: 1 = div, 0 = mul
//  wb_valid        out  1   one-cycle writeback strobe
//  wb_rd           out  5   writeback register: rd, or STATUS_REG on exception
//  wb_use_status   out  1   1 = write wb_status, 0 = write datapath result
//  wb_status       out  32  zero-extended MUL_EXC or DIV_EXC; 0 otherwise
//  busy            out  1   state != IDLE
// BEHAVIOUR
//  Reset: state IDLE, counter 0, all registered state 0; every output 0.
//  req = valid_in & ~flush & opcode==00000 & (aluop==00110 | aluop==00111).
//  IDLE:
//   - On req: stall=1 and dp_load=1 (same cycle, combinational).
//   - Latch rd_in, is_div, and dz = is_div & (operand_b==0); clear counter.
//   - Next state: DONE if dz, else BUSY.
//  BUSY:
//   - stall=1, dp_step=1; counter increments each cycle.
//   - After the step with counter==ITER-1, next state is DONE.
//   - Exactly ITER step cycles.
//  DONE (one cycle):
//   - stall=0 and wb_valid=1, so the pipeline advances with the result.
//   - Next state is always IDLE. req is ignored in DONE: X still holds the same instruction.
//   - Exception when dz, or when ~is_div & dp_overflow:
//     wb_rd=STATUS_REG, wb_use_status=1, wb_status = DIV_EXC (dz) or MUL_EXC (overflow).
//   - Otherwise: wb_rd = latched rd, wb_use_status=0, wb_status=0.
//  Latency, normal op:
//   - Request cycle + ITER BUSY cycles, stall high for ITER+1 cycles.
//   - wb_valid in cycle ITER+1 after request.
//  Latency, div by zero: stall high for 1 cycle; wb_valid in the following cycle.
//  Back-to-back mul/div: the next req is accepted in the IDLE cycle after DONE. No bubble beyond that.
//  flush:
//   - flush in IDLE blocks req.
//   - flush in BUSY aborts to IDLE next cycle: stall and dp_step drop, no wb_valid.
//   - flush in DONE suppresses wb_valid.
//  Non-mul/div instructions: the block is transparent, with stall=0 and all strobes 0.
//  reset asserted mid-operation: returns to IDLE on the next edge; no wb_valid is ever emitted for the aborted op.
//  dp_is_div holds its latched value until the next load.
// STRUCTURE
//  Shared package (proc_defs):
//   - OP_RTYPE=5'b00000, ALU_MUL=5'b00110, ALU_DIV=5'b00111.
//   - MUL_EXC, DIV_EXC, STATUS_REG.
//   - State encoding: IDLE, BUSY, DONE.
//  Sub-module iter_counter (CNT_W-bit; clr, en, terminal = count==ITER-1) instantiated once.
//  The FSM and output decode stay in this module.
// TESTING
//  1. mul, A=6 B=7, no overflow -> stall 33 cycles; dp_load at cycle 0; dp_step cycles 1..32;
//     cycle 33 wb_valid=1, wb_rd=rd_in, wb_use_status=0.
//  2. div, B=0 -> stall 1 cycle, no dp_step; next cycle wb_valid=1, wb_rd=30, wb_status=5.
//  3. mul with dp_overflow=1 in DONE -> wb_rd=30, wb_use_status=1, wb_status=4.
//  4. flush at BUSY step 10 -> next cycle state IDLE, stall=0; no wb_valid for 40 cycles.
//  5. mul then div back-to-back -> second dp_load in the cycle after the first wb_valid;
//     dp_is_div=1 for the second op.
//  6. reset at BUSY step 5 -> all outputs 0 next cycle; an add (opcode 00000, ALUop 00000) then never stalls.

Source files
------------

// File: rtl/proc_defs.sv
// Shared processor definitions used by the X-stage mul/div sequencer.
package proc_defs;

  // Instruction field encodings seen in the X stage
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  // Exception reporting through $rstatus
  localparam int STATUS_REG = 30;
  localparam int MUL_EXC    = 4;
  localparam int DIV_EXC    = 5;

  // Sequencer state encoding
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // True for an R-type instruction whose ALUop selects mul or div
  function automatic logic is_muldiv(input logic [4:0] opcode, input logic [4:0] aluop);
    return (opcode == OP_RTYPE) && ((aluop == ALU_MUL) || (aluop == ALU_DIV));
  endfunction

endpackage

// File: rtl/iter_counter.sv
// Iteration counter for the multi-cycle datapath: clear on load, count steps,
// flag the last step.
module iter_counter #(
  parameter int ITER  = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             terminal
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear has priority over enable so a new load always starts from zero
  always_comb begin
    count_d = count_q;
    if (clr)     count_d = '0;
    else if (en) count_d = count_q + 1'b1;
  end

  // Counter register, synchronously reset
  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count    = count_q;
  assign terminal = (count_q == CNT_W'(ITER - 1));

endmodule

// File: rtl/multdiv_sequencer.sv
// X-stage sequencer for the iterative multiply/divide datapath. Stalls the
// front of the pipe, loads and steps the datapath, then issues a one-cycle
// writeback of either the result or an exception code to $rstatus.
module multdiv_sequencer #(
  parameter int ITER       = 32,
  parameter int CNT_W      = 6,
  parameter int STATUS_REG = proc_defs::STATUS_REG,
  parameter int MUL_EXC    = proc_defs::MUL_EXC,
  parameter int DIV_EXC    = proc_defs::DIV_EXC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [4:0]  opcode,
  input  logic [4:0]  aluop,
  input  logic [4:0]  rd_in,
  input  logic [31:0] operand_b,
  input  logic        flush,
  input  logic        dp_overflow,
  output logic        stall,
  output logic        dp_load,
  output logic        dp_step,
  output logic        dp_is_div,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_use_status,
  output logic [31:0] wb_status,
  output logic        busy
);

  import proc_defs::state_e;
  import proc_defs::S_IDLE;
  import proc_defs::S_BUSY;
  import proc_defs::S_DONE;
  import proc_defs::ALU_DIV;
  import proc_defs::is_muldiv;

  state_e     state_q, state_d;
  logic [4:0] rd_q, rd_d;
  logic       is_div_q, is_div_d;
  logic       dz_q, dz_d;

  logic             req;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_last;
  logic [CNT_W-1:0] cnt_val;
  logic             done_act;
  logic             exc;

  iter_counter #(
    .ITER  (ITER),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clock    (clock),
    .reset    (reset),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .count    (cnt_val),
    .terminal (cnt_last)
  );

  // Request qualification: reset and flush both block a new operation
  assign req = ~reset & valid_in & ~flush & is_muldiv(opcode, aluop);

  // Next-state and datapath control decode
  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    is_div_d = is_div_q;
    dz_d     = dz_q;
    stall    = 1'b0;
    dp_load  = 1'b0;
    dp_step  = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          stall    = 1'b1;
          dp_load  = 1'b1;
          cnt_clr  = 1'b1;
          rd_d     = rd_in;
          is_div_d = (aluop == ALU_DIV);
          dz_d     = (aluop == ALU_DIV) && (operand_b == '0);
          // Divide by zero skips the datapath entirely
          state_d  = dz_d ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        stall   = 1'b1;
        dp_step = 1'b1;
        cnt_en  = 1'b1;
        if (flush)         state_d = S_IDLE;
        else if (cnt_last) state_d = S_DONE;
      end
      S_DONE: begin
        // X still holds the finished instruction here, so req is not looked at
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Keep every strobe quiet while reset is asserted
    if (reset) begin
      stall   = 1'b0;
      dp_load = 1'b0;
      dp_step = 1'b0;
    end
  end

  // State and latched-operation registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rd_q     <= '0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      is_div_q <= is_div_d;
      dz_q     <= dz_d;
    end
  end

  // Writeback decode: exception redirects the write to $rstatus
  always_comb begin
    done_act      = (state_q == S_DONE) & ~reset;
    exc           = dz_q | (~is_div_q & dp_overflow);
    wb_valid      = done_act & ~flush;
    wb_use_status = done_act & exc;
    wb_rd         = '0;
    wb_status     = '0;
    if (done_act) begin
      wb_rd = exc ? 5'(STATUS_REG) : rd_q;
      if (exc) wb_status = dz_q ? 32'(DIV_EXC) : 32'(MUL_EXC);
    end
  end

  assign dp_is_div = is_div_q;
  assign busy      = (state_q != S_IDLE) & ~reset;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer with a writeback scoreboard.
module tb_multdiv_sequencer;

  localparam int ITER = 32;
  localparam logic [4:0] MUL_C = 5'b00110;
  localparam logic [4:0] DIV_C = 5'b00111;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [4:0]  opcode;
  logic [4:0]  aluop;
  logic [4:0]  rd_in;
  logic [31:0] operand_b;
  logic        flush;
  logic        dp_overflow;
  logic        stall, dp_load, dp_step, dp_is_div, wb_valid, wb_use_status, busy;
  logic [4:0]  wb_rd;
  logic [31:0] wb_status;

  typedef struct {
    logic [4:0]  rd;
    logic        use_status;
    logic [31:0] status;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  multdiv_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .valid_in      (valid_in),
    .opcode        (opcode),
    .aluop         (aluop),
    .rd_in         (rd_in),
    .operand_b     (operand_b),
    .flush         (flush),
    .dp_overflow   (dp_overflow),
    .stall         (stall),
    .dp_load       (dp_load),
    .dp_step       (dp_step),
    .dp_is_div     (dp_is_div),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_use_status (wb_use_status),
    .wb_status     (wb_status),
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    valid_in = 1'b0; opcode = 5'd0; aluop = 5'd0; rd_in = 5'd0;
    operand_b = 32'd0; flush = 1'b0; dp_overflow = 1'b0;
  endtask

  // Writeback scoreboard: every wb_valid must match the oldest expected entry
  always @(negedge clock) begin
    if (!reset && wb_valid) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_rd", 32'(wb_rd), 32'(e.rd));
        chk("wb_use_status", 32'(wb_use_status), 32'(e.use_status));
        chk("wb_status", wb_status, e.status);
      end
    end
  end

  // Issue one mul/div from IDLE and follow it up to and including its DONE cycle
  task automatic run_op(input bit div, input logic [4:0] rd, input logic [31:0] b,
                        input bit ovf, input string tag);
    int   nstep, nstall, nload;
    bit   dz;
    exp_t e;
    dz = div && (b == 32'd0);
    step();
    valid_in = 1'b1; opcode = 5'd0; aluop = div ? DIV_C : MUL_C;
    rd_in = rd; operand_b = b; flush = 1'b0; dp_overflow = 1'b0;
    #1;
    chk({tag, ":load"}, 32'(dp_load), 32'd1);
    chk({tag, ":stall0"}, 32'(stall), 32'd1);
    chk({tag, ":busy0"}, 32'(busy), 32'd0);
    if (dz) begin
      e.rd = 5'd30; e.use_status = 1'b1; e.status = 32'd5;
    end else if (!div && ovf) begin
      e.rd = 5'd30; e.use_status = 1'b1; e.status = 32'd4;
    end else begin
      e.rd = rd; e.use_status = 1'b0; e.status = 32'd0;
    end
    exp_q.push_back(e);
    nstep = 0; nstall = 0; nload = 0;
    if (!dz) begin
      for (int i = 0; i < ITER; i++) begin
        step(); #1;
        nstep += int'(dp_step); nstall += int'(stall); nload += int'(dp_load);
      end
    end
    chk({tag, ":steps"}, 32'(nstep), dz ? 32'd0 : 32'(ITER));
    chk({tag, ":stalls"}, 32'(nstall), dz ? 32'd0 : 32'(ITER));
    chk({tag, ":reload"}, 32'(nload), 32'd0);
    step();
    dp_overflow = ovf;
    #1;
    chk({tag, ":done_stall"}, 32'(stall), 32'd0);
    chk({tag, ":done_wb"}, 32'(wb_valid), 32'd1);
    chk({tag, ":is_div"}, 32'(dp_is_div), 32'(div));
  endtask

  initial begin
    int nwb, nst;
    idle_inputs();
    reset = 1'b1;
    // Reset with a live mul request on the inputs: everything must stay quiet
    valid_in = 1'b1; aluop = MUL_C; rd_in = 5'd3; operand_b = 32'd7;
    step(); step();
    #1;
    chk("rst:stall", 32'(stall), 32'd0);
    chk("rst:load", 32'(dp_load), 32'd0);
    chk("rst:wb", 32'(wb_valid), 32'd0);
    chk("rst:busy", 32'(busy), 32'd0);
    idle_inputs();
    step();
    reset = 1'b0;
    #1;
    chk("post_rst:status", wb_status, 32'd0);
    chk("post_rst:is_div", 32'(dp_is_div), 32'd0);

    // Flush in IDLE blocks the request
    valid_in = 1'b1; aluop = MUL_C; rd_in = 5'd9; flush = 1'b1;
    #1;
    chk("flush_idle:stall", 32'(stall), 32'd0);
    chk("flush_idle:load", 32'(dp_load), 32'd0);
    step(); #1;
    chk("flush_idle:busy", 32'(busy), 32'd0);
    idle_inputs();

    // 1: plain mul
    run_op(1'b0, 5'd12, 32'd7, 1'b0, "mul");
    step(); idle_inputs(); #1;
    chk("mul:idle_after", 32'(busy), 32'd0);

    // 2: div by zero
    run_op(1'b1, 5'd8, 32'd0, 1'b0, "divz");
    step(); idle_inputs();

    // 3: mul overflow
    run_op(1'b0, 5'd17, 32'd3, 1'b1, "mulovf");
    step(); idle_inputs();

    // 5: mul then div back to back; div load lands the cycle after the mul writeback
    run_op(1'b0, 5'd4, 32'd6, 1'b0, "b2b_mul");
    run_op(1'b1, 5'd21, 32'd3, 1'b0, "b2b_div");
    // Divides never raise the mul-overflow exception
    run_op(1'b1, 5'd22, 32'd9, 1'b1, "div_ovfin");
    step(); idle_inputs();

    // 4: flush on the 10th BUSY cycle
    step();
    valid_in = 1'b1; aluop = MUL_C; rd_in = 5'd11; operand_b = 32'd5;
    for (int i = 0; i < 10; i++) step();
    flush = 1'b1;
    step(); idle_inputs(); #1;
    chk("flush_busy:stall", 32'(stall), 32'd0);
    chk("flush_busy:busy", 32'(busy), 32'd0);
    chk("flush_busy:step", 32'(dp_step), 32'd0);
    nwb = 0;
    for (int i = 0; i < 40; i++) begin step(); nwb += int'(wb_valid); end
    chk("flush_busy:no_wb", 32'(nwb), 32'd0);

    // 6: reset on the 5th BUSY cycle, then an add must pass through untouched
    step();
    valid_in = 1'b1; aluop = DIV_C; rd_in = 5'd13; operand_b = 32'd5;
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    step(); reset = 1'b0; idle_inputs(); #1;
    chk("rst_busy:stall", 32'(stall), 32'd0);
    chk("rst_busy:busy", 32'(busy), 32'd0);
    chk("rst_busy:is_div", 32'(dp_is_div), 32'd0);
    chk("rst_busy:wb_rd", 32'(wb_rd), 32'd0);
    valid_in = 1'b1; opcode = 5'd0; aluop = 5'd0; rd_in = 5'd2; operand_b = 32'd1;
    nwb = 0; nst = 0;
    for (int i = 0; i < 40; i++) begin
      step(); nwb += int'(wb_valid); nst += int'(stall) + int'(dp_load) + int'(dp_step);
    end
    chk("add:no_stall", 32'(nst), 32'd0);
    chk("add:no_wb", 32'(nwb), 32'd0);
    idle_inputs();
    step();
    chk("sb:empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
